// File: rtl/pipe_add_sub.sv
// -----------------------------------------------------------------------------
// pipe_add_sub
//   Pipelined two's-complement adder/subtractor with valid/ready handshakes.
//   The WIDTH-bit addition is split into STAGES segments of SEG bits. Each
//   stage adds one segment and registers its carry for the next stage, so the
//   longest carry chain is SEG bits. Operand bits not yet added travel down
//   the pipe with the beat; finished sum bits are carried forward with it.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   operand beat offered
//   in_ready   out  beat accepted this cycle if in_valid is high
//   x, y       in   operands A and B (WIDTH bits)
//   cin        in   carry-in (add mode only)
//   sub        in   0 = x + y + cin, 1 = x - y
//   out_valid  out  result beat present
//   out_ready  in   downstream takes the result this cycle
//   sum        out  result (WIDTH bits)
//   cout       out  carry out of the MSB (1 = no borrow when subtracting)
//   ovf        out  signed overflow
//   zero       out  sum == 0
// -----------------------------------------------------------------------------
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  // Pipeline registers; index k holds the beat after segment k was added.
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_x     [STAGES];
  logic [WIDTH-1:0]  r_y     [STAGES];
  logic [WIDTH-1:0]  r_sum   [STAGES];
  logic              r_carry [STAGES];
  logic              r_ovf;
  logic              r_zero;

  // Per-stage combinational inputs and next-state values.
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic              w_c_in  [STAGES];
  logic [SEG:0]      w_seg   [STAGES];
  logic [WIDTH-1:0]  w_sum_n [STAGES];
  logic              w_c_n   [STAGES];

  logic [WIDTH-1:0]  w_y_eff;
  logic              w_stall;
  logic              w_ovf_n;
  logic              w_zero_n;

  // Subtraction is x + ~y + 1: invert y and force the carry-in.
  assign w_y_eff  = sub ? ~y : y;

  // The whole pipe freezes while the output beat is refused downstream.
  assign w_stall  = r_vld[STAGES-1] & ~out_ready;
  assign in_ready = ~w_stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

    if (k == 0) begin : g_first
      assign w_a_in[k] = x;
      assign w_b_in[k] = w_y_eff;
      assign w_c_in[k] = sub ? 1'b1 : cin;
      assign w_s_in[k] = {WIDTH{1'b0}};
    end else begin : g_next
      assign w_a_in[k] = r_x[k-1];
      assign w_b_in[k] = r_y[k-1];
      assign w_c_in[k] = r_carry[k-1];
      assign w_s_in[k] = r_sum[k-1];
    end

    // SEG-bit slice add; the extra top bit is this stage's carry-out.
    assign w_seg[k]   = {1'b0, w_a_in[k][k*SEG +: SEG]}
                      + {1'b0, w_b_in[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, w_c_in[k]};
    // Splice the new segment into the partial sum carried with the beat.
    assign w_sum_n[k] = (w_s_in[k] & ~SEG_MASK)
                      | (WIDTH'(w_seg[k][SEG-1:0]) << (k * SEG));
    assign w_c_n[k]   = w_seg[k][SEG];
  end

  // Flags come from the final stage, where the complete sum first exists.
  assign w_ovf_n  = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1])
                 && (w_sum_n[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);
  assign w_zero_n = (w_sum_n[STAGES-1] == {WIDTH{1'b0}});

  // Pipeline advance: every stage shifts together unless stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= {STAGES{1'b0}};
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]     <= {WIDTH{1'b0}};
        r_y[k]     <= {WIDTH{1'b0}};
        r_sum[k]   <= {WIDTH{1'b0}};
        r_carry[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      // in_ready is 1 here, so in_valid alone says whether a beat enters.
      r_vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]     <= w_a_in[k];
        r_y[k]     <= w_b_in[k];
        r_sum[k]   <= w_sum_n[k];
        r_carry[k] <= w_c_n[k];
      end
      r_ovf  <= w_ovf_n;
      r_zero <= w_zero_n;
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_carry[STAGES-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// -----------------------------------------------------------------------------
// tb_pipe_add_sub
//   Scoreboard bench for pipe_add_sub: a 32-bit/4-stage instance driven with
//   directed, random, stalled and reset-interrupted streams, plus an
//   8-bit/1-stage instance for the single-stage corner.
// -----------------------------------------------------------------------------
module tb_pipe_add_sub;

  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0] x, y, sum;
  logic         cout, ovf, zero;

  logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
  logic [7:0]   x8, y8, sum8;
  logic         cout8, ovf8, zero8;

  pipe_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  bit   front_seen = 1'b0;
  bit   drv_lat    = 1'b1;
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: plain full-width add of x and effective y.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   r;
    exp_t         e;
    be     = s ? ~b : b;
    ce     = s ? 1'b1 : c;
    r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    e.zero = (r[W-1:0] == {W{1'b0}});
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the output beat with the queue front, pop on handshake,
  // then push the beat about to be accepted at the coming edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          e = q[0];
          check("sum",  sum,  e.sum);
          check("cout", cout, e.cout);
          check("ovf",  ovf,  e.ovf);
          check("zero", zero, e.zero);
          if (!front_seen && e.lat) check("latency", cyc - e.acc, S - 1);
          front_seen = 1'b1;
          if (out_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e     = model(x, y, cin, sub);
        e.acc = cyc + 1;
        e.lat = drv_lat;
        q.push_back(e);
      end
    end
  end

  // Offer one beat (entered just after a rising edge), wait for acceptance.
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
    int n;
    n = 0;
    in_valid = 1'b1; x = a; y = b; cin = c; sub = s;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain", q.size(), 64'd0);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no end, expected end of test");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] bx [8];
    logic [W-1:0] by [8];
    logic         bc [8];
    logic         bs [8];
    int           idx, c;
    logic         acc;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = {W{1'b0}}; y = {W{1'b0}}; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = 8'h00; y8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_sum",       sum,       {W{1'b0}});
    check("rst_cout",      cout,      1'b0);
    check("rst_ovf",       ovf,       1'b0);
    check("rst_zero",      zero,      1'b0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-stage 8-bit instance: result one edge after acceptance.
    x8 = 8'h80; y8 = 8'h80; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready",  in_ready8,  1'b1);
    check("w8_pre_valid", out_valid8, 1'b0);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_out_valid", out_valid8, 1'b1);
    check("w8_sum",       sum8,       8'h01);
    check("w8_cout",      cout8,      1'b1);
    check("w8_ovf",       ovf8,       1'b1);
    check("w8_zero",      zero8,      1'b0);
    @(negedge clk);
    check("w8_post_valid", out_valid8, 1'b0);
    @(posedge clk);
    #1;

    // Directed corners, one beat at a time.
    drive_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();
    drive_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();
    drive_beat(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1); drain();
    drive_beat(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1); drain();
    drive_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0); drain();
    drive_beat(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1); drain();
    drive_beat(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0); drain();

    // Back-to-back random stream, out_ready held high: one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Eight beats with out_ready low in cycles 5..7 of the stream.
    drv_lat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bx[i] = $urandom; by[i] = $urandom;
      bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    c   = 0;
    while (idx < 8 && c < 40) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = 1'b1;
      x = bx[idx]; y = by[idx]; cin = bc[idx]; sub = bs[idx];
      @(negedge clk);
      check("stall_in_ready", in_ready, (c >= 5 && c <= 7) ? 1'b0 : 1'b1);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_beats_accepted", idx, 8);
    drain();
    drv_lat = 1'b1;

    // Reset with three beats in the pipe and one on the output.
    for (int i = 0; i < 5; i++) begin
      drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("pre_reset_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    q.delete();
    front_seen = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready,  1'b1);
    check("async_rst_sum",   sum,       {W{1'b0}});
    check("async_rst_cout",  cout,      1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    drive_beat(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4: pipeline depth; SHALL be >= 1 and SHALL divide WIDTH exactly; SEG = WIDTH/STAGES bits are added per stage.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 x  input  WIDTH  operand A.
REQ-008 y  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only in add mode.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Accept: a beat SHALL be taken on a rising edge where in_valid && in_ready.
REQ-018 Add mode: {cout,sum} SHALL equal x + y + cin, computed modulo 2^(WIDTH+1).
REQ-019 Subtract mode: {cout,sum} SHALL equal x + ~y + 1, and cin SHALL be ignored; cout=1 means no borrow.
REQ-020 ovf SHALL be (x_msb == y_eff_msb) && (sum_msb != x_msb), where y_eff is y in add mode and ~y in subtract mode.
REQ-021 Structure: stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] of x and y_eff with the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-022 Per stage, operand bits above the current segment SHALL be skew-delayed in registers and completed sum bits SHALL be carried forward, so no carry path spans more than SEG bits combinationally.
REQ-023 A per-stage valid bit SHALL accompany each beat; bubbles propagate as invalid slots.
REQ-024 Stall = out_valid && !out_ready; in_ready SHALL be !stall, driven combinationally.
REQ-025 While stall is 1, every pipeline register, including valid bits, SHALL hold its value; while stall is 0, all stages SHALL advance one position per cycle.
REQ-026 Latency: with no stall, a beat accepted at edge N SHALL present out_valid=1 with its result after edge N+STAGES-1; STAGES=1 gives result after the accepting edge.
REQ-027 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-028 Results SHALL emerge in acceptance order; no beat SHALL be dropped or duplicated.
REQ-029 sum, cout, ovf and zero SHALL be stable while out_valid && !out_ready.
REQ-030 sum, cout, ovf and zero SHALL be don't-care while out_valid=0.
REQ-031 Simultaneous pop and push: when out_valid && out_ready, a new beat SHALL be accepted in the same cycle.

Reset
REQ-032 reset_n=0 SHALL asynchronously clear all valid bits, so out_valid=0 and in_ready=1 immediately.
REQ-033 reset_n=0 SHALL drive sum, cout, ovf and zero to 0.
REQ-034 Beats in flight during reset SHALL be discarded, and no result SHALL appear for them.
REQ-035 Deassertion of reset_n SHALL be effective at the first rising clock edge after deassertion.

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-036 x=0xFFFFFFFF, y=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, zero=1, ovf=0, out_valid after accept edge +3.
REQ-037 x=0x7FFFFFFF, y=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-038 x=5, y=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; x=7, y=5, sub=1 -> sum=0x00000002, cout=1.
REQ-039 Stream 8 random beats back-to-back, hold out_ready=0 for cycles 5-7 -> in_ready=0 in exactly those cycles, outputs frozen, all 8 results correct and in order.
REQ-040 reset_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale result after release, next beat correct at latency 4.
REQ-041 WIDTH=8, STAGES=1: x=0x80, y=0x80, cin=1 -> sum=0x01, cout=1, ovf=1, latency 1 cycle.
